// File: rtl/xor_unit_arbiter.sv
// xor_unit_arbiter
// Shares one registered XOR unit (res = A ^ B) among NREQ requesters.
// Round-robin arbitration in IDLE. A winner that also asserts lock keeps
// ownership in BURST for up to BURST_MAX back-to-back grants.
// Results appear one cycle after the grant, tagged with the requester index.
// Optional feature macro: XOR_ARB_PARITY_EN adds res_par, the even parity
// (reduction XOR) of res_data, registered alongside it.

module xor_unit_arbiter #(
    parameter  int NREQ      = 4,
    parameter  int W         = 8,
    parameter  int BURST_MAX = 4,
    localparam int IDW       = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   lock,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic              res_valid,
    output logic [W-1:0]      res_data,
    output logic [IDW-1:0]    res_id,
`ifdef XOR_ARB_PARITY_EN
    output logic              res_par,
`endif
    output logic              busy
);

    // Counter must be able to hold BURST_MAX itself.
    localparam int CW       = $clog2(BURST_MAX + 1);
    localparam bit BURST_EN = (BURST_MAX > 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [IDW-1:0]     ptr_r;
    logic [IDW-1:0]     ptr_nx_s;
    logic [IDW-1:0]     owner_r;
    logic [IDW-1:0]     owner_nx_s;
    logic [CW-1:0]      cnt_r;
    logic [CW-1:0]      cnt_nx_s;
    logic [CW-1:0]      cnt_inc_s;
    logic               busy_r;

    logic [IDW-1:0]     win_s;
    logic               win_found_s;
    logic               grant_s;
    logic [IDW-1:0]     gid_s;
    logic [NREQ-1:0]    gnt_s;

    logic [W-1:0]       a_arr_s [NREQ];
    logic [W-1:0]       b_arr_s [NREQ];
    logic [W-1:0]       op_x_s;

    logic               res_valid_r;
    logic [W-1:0]       res_data_r;
    logic [IDW-1:0]     res_id_r;

    // Requester index ptr+k, wrapped modulo NREQ (works for non-power-of-2 NREQ).
    function automatic logic [IDW-1:0] rr_idx_f(input logic [IDW-1:0] p, input int k);
        return IDW'((int'(p) + k) % NREQ);
    endfunction

    // Even parity of a result word.
    function automatic logic parity_f(input logic [W-1:0] d);
        return ^d;
    endfunction

    // Unpack the flat operand buses into per-requester words.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr_s[g] = a_in[g*W +: W];
        assign b_arr_s[g] = b_in[g*W +: W];
    end

    // Round-robin winner: scan from the far end back toward ptr+1 so the
    // last overwrite is the first requester after ptr.
    always_comb begin
        win_s       = {IDW{1'b0}};
        win_found_s = |req;
        for (int k = NREQ; k >= 1; k--) begin
            win_s = req[rr_idx_f(ptr_r, k)] ? rr_idx_f(ptr_r, k) : win_s;
        end
    end

    assign cnt_inc_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};

    // Next-state, grant decision and bookkeeping updates.
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        owner_nx_s = owner_r;
        cnt_nx_s   = cnt_r;
        grant_s    = 1'b0;
        gid_s      = owner_r;
        gnt_s      = {NREQ{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (en && win_found_s) begin
                    grant_s    = 1'b1;
                    gid_s      = win_s;
                    ptr_nx_s   = win_s;
                    owner_nx_s = win_s;
                    if (BURST_EN && lock[win_s]) begin
                        state_nx_s = ST_BURST;
                        cnt_nx_s   = {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        state_nx_s = ST_IDLE;
                        cnt_nx_s   = {CW{1'b0}};
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (!en) begin
                    // Frozen: no grant, state and count held.
                    state_nx_s = ST_BURST;
                end else if (req[owner_r]) begin
                    grant_s  = 1'b1;
                    gid_s    = owner_r;
                    cnt_nx_s = cnt_inc_s;
                    // A beat granted with lock dropped is the last one.
                    if ((cnt_inc_s >= CW'(BURST_MAX)) || !lock[owner_r]) begin
                        state_nx_s = ST_IDLE;
                        cnt_nx_s   = {CW{1'b0}};
                    end else begin
                        state_nx_s = ST_BURST;
                    end
                end else begin
                    // Owner withdrew its request: release without a grant.
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = {CW{1'b0}};
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = {CW{1'b0}};
            end
        endcase
        if (grant_s) begin
            gnt_s[gid_s] = 1'b1;
        end else begin
            gnt_s = {NREQ{1'b0}};
        end
    end

    // Grant is combinational but forced low while reset is asserted.
    assign gnt    = gnt_s & {NREQ{reset}};
    assign op_x_s = a_arr_s[gid_s] ^ b_arr_s[gid_s];

    // Arbiter state, round-robin pointer, burst owner/count and busy flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= IDW'(NREQ - 1);
            owner_r <= {IDW{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
            owner_r <= owner_nx_s;
            cnt_r   <= cnt_nx_s;
            busy_r  <= (state_nx_s == ST_BURST);
        end
    end

    // Shared XOR unit: capture the granted requester's result one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_valid_r <= 1'b0;
            res_data_r  <= {W{1'b0}};
            res_id_r    <= {IDW{1'b0}};
        end else if (grant_s) begin
            res_valid_r <= 1'b1;
            res_data_r  <= op_x_s;
            res_id_r    <= gid_s;
        end else begin
            res_valid_r <= 1'b0;
        end
    end

`ifdef XOR_ARB_PARITY_EN
    logic res_par_r;

    // Parity tracks res_data: updated on grants, held otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_par_r <= 1'b0;
        end else if (grant_s) begin
            res_par_r <= parity_f(op_x_s);
        end else begin
            res_par_r <= res_par_r;
        end
    end

    assign res_par = res_par_r;
`endif

    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;
    assign res_id    = res_id_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Testbench for xor_unit_arbiter: randomized and directed stimulus, a
// behavioural arbitration model, and a scoreboard queue drained by a
// separate monitor process whenever a result is due.

module tb_xor_unit_arbiter;

    localparam int NREQ      = 4;
    localparam int W         = 8;
    localparam int BURST_MAX = 4;
    localparam int IDW       = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              en;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   lock;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic              res_valid;
    logic [W-1:0]      res_data;
    logic [IDW-1:0]    res_id;
    logic              busy;
`ifdef XOR_ARB_PARITY_EN
    logic              res_par;
`endif

    xor_unit_arbiter #(.NREQ(NREQ), .W(W), .BURST_MAX(BURST_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .lock      (lock),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
`ifdef XOR_ARB_PARITY_EN
        .res_par   (res_par),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: who owns the unit and how many beats it has used.
    int   m_ptr;
    int   m_owner;
    int   m_used;
    bit   m_burst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = NREQ - 1;
        m_owner = 0;
        m_used  = 0;
        m_burst = 1'b0;
        exp_q.delete();
    endtask

    // Predict this cycle's grant from the current inputs, check gnt/busy,
    // queue the expected result and advance the model past the next edge.
    task automatic eval();
        int              w;
        logic [NREQ-1:0] eg;
        exp_t            e;
        chk("busy", 32'(busy), 32'(m_burst));
        w = -1;
        if (!m_burst) begin
            if (en) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                end
            end
            if (w >= 0) begin
                m_ptr   = w;
                m_owner = w;
                if (lock[w] && BURST_MAX > 1) begin
                    m_burst = 1'b1;
                    m_used  = 1;
                end
            end
        end else if (en) begin
            if (req[m_owner]) begin
                w = m_owner;
                m_used++;
                if (m_used == BURST_MAX || !lock[m_owner]) m_burst = 1'b0;
            end else begin
                m_burst = 1'b0;
            end
        end
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        if (w >= 0) begin
            e.id   = IDW'(w);
            e.data = a_in[w*W +: W] ^ b_in[w*W +: W];
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc(input logic e, input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                       input logic [NREQ*W-1:0] a, input logic [NREQ*W-1:0] b);
        @(posedge clk);
        #1;
        en   = e;
        req  = r;
        lock = l;
        a_in = a;
        b_in = b;
        #3;
        eval();
    endtask

    // Scoreboard monitor: one result is due exactly one cycle after each grant.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("res_valid", 32'(res_valid), 32'd1);
                chk("res_id", 32'(res_id), 32'(e.id));
                chk("res_data", 32'(res_data), 32'(e.data));
            end else begin
                chk("res_valid_idle", 32'(res_valid), 32'd0);
            end
`ifdef XOR_ARB_PARITY_EN
            chk("res_par", 32'(res_par), 32'(^res_data));
`endif
        end
    end

    initial begin : stimulus
        logic [NREQ*W-1:0] a0;
        logic [NREQ*W-1:0] b0;
        reset = 1'b0;
        en    = 1'b1;
        req   = 4'b1111;
        lock  = 4'b0000;
        a_in  = '0;
        b_in  = '0;
        model_reset();

        // Held in reset with every request asserted.
        repeat (3) begin
            @(posedge clk);
            #4;
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_res_data", 32'(res_data), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end

        // First cycle after release: requester 0 wins, A5 ^ 0F.
        @(posedge clk);
        #1;
        reset = 1'b1;
        a0 = {$urandom()};
        b0 = {$urandom()};
        a0[7:0] = 8'hA5;
        b0[7:0] = 8'h0F;
        a_in = a0;
        b_in = b0;
        #3;
        eval();
        cyc(1'b1, 4'b1111, 4'b0000, {$urandom()}, {$urandom()});
        chk("first_res_data", 32'(res_data), 32'h0000_00AA);
        chk("first_res_id", 32'(res_id), 32'd0);

        // Plain round robin over all requesters.
        repeat (4) cyc(1'b1, 4'b1111, 4'b0000, {$urandom()}, {$urandom()});

        // Locked burst by requester 2 competing with requester 0.
        repeat (2) cyc(1'b1, 4'b0000, 4'b0000, {$urandom()}, {$urandom()});
        repeat (8) cyc(1'b1, 4'b0101, 4'b0100, {$urandom()}, {$urandom()});

        // Burst by requester 1 with lock dropped on its second beat.
        repeat (2) cyc(1'b1, 4'b0000, 4'b0000, {$urandom()}, {$urandom()});
        cyc(1'b1, 4'b0010, 4'b0010, {$urandom()}, {$urandom()});
        repeat (3) cyc(1'b1, 4'b1111, 4'b0000, {$urandom()}, {$urandom()});

        // Enable stalled mid-burst, then the remaining beats resume.
        repeat (2) cyc(1'b1, 4'b0000, 4'b0000, {$urandom()}, {$urandom()});
        repeat (2) cyc(1'b1, 4'b0100, 4'b0100, {$urandom()}, {$urandom()});
        repeat (3) cyc(1'b0, 4'b0100, 4'b0100, {$urandom()}, {$urandom()});
        repeat (4) cyc(1'b1, 4'b0101, 4'b0100, {$urandom()}, {$urandom()});

        // Randomized traffic.
        repeat (400) begin
            cyc(($urandom_range(0, 9) != 0), NREQ'($urandom()), NREQ'($urandom()),
                {$urandom()}, {$urandom()});
        end

        // Asynchronous reset pulse between edges while bursting.
        repeat (2) cyc(1'b1, 4'b0000, 4'b0000, {$urandom()}, {$urandom()});
        repeat (2) cyc(1'b1, 4'b0100, 4'b0100, 32'h0007_0000, 32'h0000_0000);
        @(posedge clk);
        #3;
        chk("busy_pre_pulse", 32'(busy), 32'd1);
        chk("data_pre_pulse", 32'(res_data), 32'h0000_0007);
        req   = 4'b0000;
        lock  = 4'b0000;
        reset = 1'b0;
        #1;
        chk("pulse_busy", 32'(busy), 32'd0);
        chk("pulse_res_valid", 32'(res_valid), 32'd0);
        chk("pulse_res_data", 32'(res_data), 32'd0);
        chk("pulse_gnt", 32'(gnt), 32'd0);
`ifdef XOR_ARB_PARITY_EN
        chk("pulse_res_par", 32'(res_par), 32'd0);
`endif
        reset = 1'b1;
        model_reset();

        // More random traffic after the pulse.
        repeat (100) begin
            cyc(($urandom_range(0, 9) != 0), NREQ'($urandom()), NREQ'($urandom()),
                {$urandom()}, {$urandom()});
        end
        cyc(1'b0, 4'b0000, 4'b0000, '0, '0);
        @(posedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
